parser_cfg_loader: RTL and testbench

- Sequences programming of the parser's header-module table from a configuration image held in packet SRAM.
- On a start pulse it reads a record count, then fixed-size records, through the single mem port (same protocol as the processor's mem port).
- It issues one ps_mod_start pulse per record, with all ps_mod fields stable.
- Sits between the mem/sram path and the parser config inputs of proc; replaces hand-driven ps_mod_* sequencing.

---
 rtl/parser_cfg_loader.sv | 187 ++++++++++++++++++
 tb/tb_parser_cfg_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : parser_cfg_loader
// Brief    : Walks a parser config image in SRAM and strobes each record into
//            the ps_mod_* programming port. Optional check: PS_CFG_CHECK_EN.
// Revision : 1.0
// ============================================================================
module parser_cfg_loader #(
    parameter int MAX_RECORDS = 16,
    parameter int RD_LATENCY  = 1,
    parameter int WORD_BYTES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] cfg_addr_i,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_width_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        ps_mod_start_o,
    output logic [31:0] ps_mod_hdr_id_o,
    output logic [31:0] ps_mod_hdr_len_o,
    output logic [31:0] ps_mod_next_tag_start_o,
    output logic [31:0] ps_mod_next_tag_len_o,
    output logic [63:0] ps_mod_next_table_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  rec_cnt_o,
    output logic        err_o
);
    localparam int                c_wait_w    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(RD_LATENCY - 1);
    localparam logic [31:0]       c_max_n     = 32'(MAX_RECORDS);
    localparam logic [31:0]       c_stride    = 32'(WORD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_CNT, S_WAIT_CNT, S_RD_FLD, S_WAIT_FLD, S_ISSUE, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_ptr;
    logic [2:0]          r_fld;
    logic [4:0]          r_rec;
    logic [4:0]          r_total;
    logic [c_wait_w-1:0] r_wait;
    logic                w_wait_last;
    logic [4:0]          w_clamped;
    logic                w_more;
    logic                w_rec_ok;

    assign w_wait_last = (r_wait == c_wait_last);
    assign w_clamped   = (mem_data_i > c_max_n) ? 5'(MAX_RECORDS) : mem_data_i[4:0];
    assign w_more      = (({1'b0, r_rec} + 6'd1) < {1'b0, r_total});

    assign mem_we_o    = 1'b0;
    assign mem_width_o = 4'd4;
    assign mem_data_o  = 32'd0;

`ifdef PS_CFG_CHECK_EN
    logic [32:0] w_tag_end;
    logic        r_err;

    assign w_tag_end = {1'b0, ps_mod_next_tag_start_o} + {1'b0, ps_mod_next_tag_len_o};
    assign w_rec_ok  = (ps_mod_hdr_len_o != 32'd0) && (w_tag_end <= {1'b0, ps_mod_hdr_len_o});
    assign err_o     = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_err <= 1'b0;
        end else if (r_state == S_ISSUE && !w_rec_ok) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_rec_ok = 1'b1;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        mem_ce_o       = 1'b0;
        mem_addr_o     = 32'd0;
        ps_mod_start_o = 1'b0;
        done_o         = 1'b0;
        busy_o         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:     if (start_i) w_next = S_RD_CNT;
            S_RD_CNT: begin
                mem_ce_o   = 1'b1;
                mem_addr_o = r_ptr;
                w_next     = S_WAIT_CNT;
            end
            S_WAIT_CNT: if (w_wait_last) w_next = (w_clamped == 5'd0) ? S_DONE : S_RD_FLD;
            S_RD_FLD: begin
                mem_ce_o   = 1'b1;
                mem_addr_o = r_ptr;
                w_next     = S_WAIT_FLD;
            end
            S_WAIT_FLD: if (w_wait_last) w_next = (r_fld == 3'd5) ? S_ISSUE : S_RD_FLD;
            S_ISSUE: begin
                ps_mod_start_o = w_rec_ok;
                w_next         = (w_rec_ok && w_more) ? S_RD_FLD : S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    // Image words are consecutive, so one post-incremented pointer covers
    // the count word and every field of every record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                 <= S_IDLE;
            r_ptr                   <= 32'd0;
            r_fld                   <= 3'd0;
            r_rec                   <= 5'd0;
            r_total                 <= 5'd0;
            r_wait                  <= '0;
            rec_cnt_o               <= 5'd0;
            ps_mod_hdr_id_o         <= 32'd0;
            ps_mod_hdr_len_o        <= 32'd0;
            ps_mod_next_tag_start_o <= 32'd0;
            ps_mod_next_tag_len_o   <= 32'd0;
            ps_mod_next_table_o     <= 64'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_ptr     <= cfg_addr_i;
                        r_fld     <= 3'd0;
                        r_rec     <= 5'd0;
                        rec_cnt_o <= 5'd0;
                    end
                end
                S_RD_CNT, S_RD_FLD: begin
                    r_ptr  <= r_ptr + c_stride;
                    r_wait <= '0;
                end
                S_WAIT_CNT: begin
                    if (w_wait_last) begin
                        r_total <= w_clamped;
`ifndef PS_CFG_CHECK_EN
                        rec_cnt_o <= w_clamped;
`endif
                    end else begin
                        r_wait <= r_wait + c_wait_w'(1);
                    end
                end
                S_WAIT_FLD: begin
                    if (w_wait_last) begin
                        case (r_fld)
                            3'd0:    ps_mod_hdr_id_o            <= mem_data_i;
                            3'd1:    ps_mod_hdr_len_o           <= mem_data_i;
                            3'd2:    ps_mod_next_tag_start_o    <= mem_data_i;
                            3'd3:    ps_mod_next_tag_len_o      <= mem_data_i;
                            3'd4:    ps_mod_next_table_o[63:32] <= mem_data_i;
                            3'd5:    ps_mod_next_table_o[31:0]  <= mem_data_i;
                            default: ;
                        endcase
                        r_fld <= (r_fld == 3'd5) ? 3'd0 : r_fld + 3'd1;
                    end else begin
                        r_wait <= r_wait + c_wait_w'(1);
                    end
                end
                S_ISSUE: begin
                    r_rec <= r_rec + 5'd1;
`ifdef PS_CFG_CHECK_EN
                    if (w_rec_ok) rec_cnt_o <= rec_cnt_o + 5'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parser_cfg_loader.sv
`default_nettype none
// Testbench for parser_cfg_loader: SRAM image model, table vectors, directed
// corner cases and randomized images checked against an arithmetic model.
module tb_parser_cfg_loader;
    localparam int MAXR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] cfg_addr_i;
    logic        mem_ce_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_width_o;
    logic        ps_mod_start_o;
    logic [31:0] ps_mod_hdr_id_o, ps_mod_hdr_len_o;
    logic [31:0] ps_mod_next_tag_start_o, ps_mod_next_tag_len_o;
    logic [63:0] ps_mod_next_table_o;
    logic        busy_o, done_o, err_o;
    logic [4:0]  rec_cnt_o;

    always #5 clk = ~clk;

    parser_cfg_loader #(.MAX_RECORDS(MAXR), .RD_LATENCY(1), .WORD_BYTES(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cfg_addr_i(cfg_addr_i),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .ps_mod_start_o(ps_mod_start_o), .ps_mod_hdr_id_o(ps_mod_hdr_id_o),
        .ps_mod_hdr_len_o(ps_mod_hdr_len_o), .ps_mod_next_tag_start_o(ps_mod_next_tag_start_o),
        .ps_mod_next_tag_len_o(ps_mod_next_tag_len_o), .ps_mod_next_table_o(ps_mod_next_table_o),
        .busy_o(busy_o), .done_o(done_o), .rec_cnt_o(rec_cnt_o), .err_o(err_o)
    );

    // Clocked SRAM holding the config image; unwritten words read as ~addr.
    logic [31:0] img [logic [31:0]];
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (img.exists(a)) return img[a];
        return ~a;
    endfunction
    always @(posedge clk) if (mem_ce_o) mem_data_i <= rd(mem_addr_o);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] id, len, ts, tl;
        logic [63:0] tbl;
    } pulse_t;

    pulse_t      pulses[$];
    int          done_cycs[$];
    logic [31:0] reads[$];
    int          checks = 0, errors = 0;
    int          start_edge = 0, rel = 0, bad_const = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and log what the DUT shows there.
    task automatic tick();
        @(negedge clk);
        rel = cyc - start_edge + 1;
        if (mon_en) begin
            if (ps_mod_start_o)
                pulses.push_back('{rel, ps_mod_hdr_id_o, ps_mod_hdr_len_o,
                                   ps_mod_next_tag_start_o, ps_mod_next_tag_len_o,
                                   ps_mod_next_table_o});
            if (done_o) done_cycs.push_back(rel);
            if (mem_ce_o) reads.push_back(mem_addr_o);
        end
        if (mem_we_o || mem_width_o != 4'd4 || mem_data_o != 32'd0) bad_const++;
    endtask

    task automatic put_rec(input logic [31:0] base, input int k,
                           input logic [31:0] id, len, ts, tl, hi, lo);
        logic [31:0] v[6];
        v = '{id, len, ts, tl, hi, lo};
        for (int f = 0; f < 6; f++) img[base + 32'(4 * (1 + 6 * k + f))] = v[f];
    endtask

    task automatic begin_load(input logic [31:0] base);
        pulses.delete(); done_cycs.delete(); reads.delete();
        tick();
        start_i = 1'b1; cfg_addr_i = base; start_edge = cyc + 1; mon_en = 1'b1;
        tick();
        start_i = 1'b0; cfg_addr_i = $urandom;
    endtask

    task automatic run_load(input logic [31:0] base, input int restart);
        begin_load(base);
        for (int i = 0; i < 400 && done_cycs.size() == 0; i++) begin
            tick();
            start_i = (restart != 0 && rel == restart);
            if (start_i) cfg_addr_i = base ^ 32'h1000;
        end
        start_i = 1'b0;
        chk("done seen within budget", 64'(done_cycs.size() != 0), 64'd1);
        tick(); tick();
        mon_en = 1'b0;
    endtask

    // Expected behaviour derived directly from the image layout and timing rules.
    task automatic compare_model(input logic [31:0] base, input string tag);
        pulse_t      ep[$];
        logic [31:0] er[$];
        logic [31:0] n, a;
        logic [31:0] f[6];
        int          np, edone;
        bit          eerr, ok;
        n = rd(base);
        np = (n > 32'(MAXR)) ? MAXR : int'(n);
        er.push_back(base);
        eerr = 1'b0;
        edone = 3 + 13 * np;
        for (int k = 0; k < np; k++) begin
            for (int j = 0; j < 6; j++) begin
                a = base + 32'(4 * (1 + 6 * k + j));
                er.push_back(a);
                f[j] = rd(a);
            end
            ok = 1'b1;
`ifdef PS_CFG_CHECK_EN
            ok = (f[1] != 32'd0) && ((33'(f[2]) + 33'(f[3])) <= 33'(f[1]));
`endif
            if (!ok) begin
                eerr = 1'b1;
                edone = 16 + 13 * k;
                break;
            end
            ep.push_back('{15 + 13 * k, f[0], f[1], f[2], f[3], {f[4], f[5]}});
        end
        chk({tag, " pulse count"}, 64'(pulses.size()), 64'(ep.size()));
        for (int i = 0; i < ep.size() && i < pulses.size(); i++) begin
            chk({tag, " pulse cycle"}, 64'(pulses[i].cyc), 64'(ep[i].cyc));
            chk({tag, " id/len"}, {pulses[i].id, pulses[i].len}, {ep[i].id, ep[i].len});
            chk({tag, " tag start/len"}, {pulses[i].ts, pulses[i].tl}, {ep[i].ts, ep[i].tl});
            chk({tag, " next table"}, pulses[i].tbl, ep[i].tbl);
        end
        chk({tag, " read count"}, 64'(reads.size()), 64'(er.size()));
        for (int i = 0; i < er.size() && i < reads.size(); i++)
            chk({tag, " read addr"}, 64'(reads[i]), 64'(er[i]));
        chk({tag, " done count"}, 64'(done_cycs.size()), 64'd1);
        if (done_cycs.size() > 0) chk({tag, " done cycle"}, 64'(done_cycs[0]), 64'(edone));
        chk({tag, " rec_cnt"}, 64'(rec_cnt_o), 64'(ep.size()));
        chk({tag, " err"}, 64'(err_o), 64'(eerr));
        chk({tag, " idle after done"}, 64'(busy_o), 64'd0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        int          exp_done;
        int          exp_cnt;
        logic [31:0] exp_last;
    } vec_t;

    task automatic plan_image(input logic [31:0] base, input logic [31:0] ts1, input logic [31:0] tl1);
        img.delete();
        img[base] = 32'd2;
        put_rec(base, 0, 32'd0, 32'd14, 32'd12, 32'd2, 32'h0800_0001, 32'd0);
        put_rec(base, 1, 32'd1, 32'd20, ts1, tl1, 32'd0, 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [31:0] b, ln;
        int n;
        vecs[0] = '{32'h0000_0100,  0,   3,  0, 32'h0000_0100};
        vecs[1] = '{32'h0000_0100, 40, 211, 16, 32'h0000_0280};
        vecs[2] = '{32'h0000_2000,  3,  42,  3, 32'h0000_2048};
        vecs[3] = '{32'hFFFF_FFF0,  1,  16,  1, 32'h0000_0008};
        vecs[4] = '{32'h0000_0040, 16, 211, 16, 32'h0000_01C0};
        vecs[5] = '{32'h0000_0040, 17, 211, 16, 32'h0000_01C0};

        rst = 1'b1; start_i = 1'b0; cfg_addr_i = 32'd0;
        repeat (3) tick();
        chk("reset ctrl", {busy_o, done_o, mem_ce_o, ps_mod_start_o, err_o, rec_cnt_o}, 64'd0);
        chk("reset fields", 64'(mem_addr_o | ps_mod_hdr_id_o | ps_mod_hdr_len_o |
            ps_mod_next_tag_start_o | ps_mod_next_tag_len_o), 64'd0);
        chk("reset table", ps_mod_next_table_o, 64'd0);
        rst = 1'b0;
        tick();

        // Two-record image from the reference bring-up sequence.
        plan_image(32'h100, 32'd9, 32'd1);
        run_load(32'h100, 0);
        compare_model(32'h100, "plan");
        chk("plan pulses", 64'(pulses.size()), 64'd2);
        if (pulses.size() == 2) begin
            chk("plan pulse0 cycle", 64'(pulses[0].cyc), 64'd15);
            chk("plan pulse1 cycle", 64'(pulses[1].cyc), 64'd28);
            chk("plan pulse0 table", pulses[0].tbl, 64'h0800_0001_0000_0000);
            chk("plan pulse1 len", 64'(pulses[1].len), 64'd20);
        end
        if (done_cycs.size() > 0) chk("plan done cycle", 64'(done_cycs[0]), 64'd29);
        chk("plan rec_cnt", 64'(rec_cnt_o), 64'd2);

        for (int v = 0; v < 6; v++) begin
            img.delete();
            img[vecs[v].base] = 32'(vecs[v].n);
            for (int k = 0; k < vecs[v].n && k < MAXR; k++)
                put_rec(vecs[v].base, k, 32'h10 + 32'(k), 32'd32 + 32'(k), 32'(k), 32'd4,
                        32'h0800_0000 | 32'(k), ~32'(k));
            run_load(vecs[v].base, 0);
            compare_model(vecs[v].base, $sformatf("vec%0d", v));
            if (done_cycs.size() > 0) chk("vec done cycle", 64'(done_cycs[0]), 64'(vecs[v].exp_done));
            chk("vec rec_cnt", 64'(rec_cnt_o), 64'(vecs[v].exp_cnt));
            chk("vec last read", 64'((reads.size() > 0) ? reads[$] : 32'hDEAD_BEEF), 64'(vecs[v].exp_last));
        end

        // A second start while busy must be ignored.
        plan_image(32'h100, 32'd9, 32'd1);
        run_load(32'h100, 5);
        compare_model(32'h100, "restart");

        // Reset in the middle of a load.
        plan_image(32'h100, 32'd9, 32'd1);
        begin_load(32'h100);
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        #1;
        chk("async rst ctrl", {busy_o, done_o, mem_ce_o, ps_mod_start_o, err_o, rec_cnt_o}, 64'd0);
        chk("async rst fields", 64'(mem_addr_o | ps_mod_hdr_id_o | ps_mod_hdr_len_o |
            ps_mod_next_tag_start_o | ps_mod_next_tag_len_o), 64'd0);
        chk("async rst table", ps_mod_next_table_o, 64'd0);
        chk("pulses before rst", 64'(pulses.size()), 64'd1);
        tick(); tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("no pulse after rst", 64'(pulses.size()), 64'd1);
        chk("no done after rst", 64'(done_cycs.size()), 64'd0);
        chk("idle after rst", {busy_o, mem_ce_o}, 64'd0);
        mon_en = 1'b0;

`ifdef PS_CFG_CHECK_EN
        plan_image(32'h300, 32'd20, 32'd1);
        run_load(32'h300, 0);
        compare_model(32'h300, "check");
        chk("check pulses", 64'(pulses.size()), 64'd1);
        chk("check err", 64'(err_o), 64'd1);
        chk("check rec_cnt", 64'(rec_cnt_o), 64'd1);
        if (done_cycs.size() > 0) chk("check done cycle", 64'(done_cycs[0]), 64'd29);
`endif

        for (int r = 0; r < 6; r++) begin
            img.delete();
            b = $urandom & 32'hFFFF_FFFC;
            n = $urandom_range(0, 20);
            img[b] = 32'(n);
            for (int k = 0; k < n && k < MAXR; k++) begin
                ln = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 64));
                put_rec(b, k, $urandom, ln, 32'($urandom_range(0, 40)),
                        32'($urandom_range(0, 30)), $urandom, $urandom);
            end
            run_load(b, 0);
            compare_model(b, $sformatf("rand%0d", r));
        end

        chk("constant mem outputs", 64'(bad_const), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
